// File: rtl/rob_flush_ctrl_pkg.sv
// Shared types and default configuration for the branch-misprediction flush controller.
package rob_flush_ctrl_pkg;

  localparam int CFG_N_WAY = 2;
  localparam int CFG_N_ROB = 8;
  localparam int CDB_BITS  = 6;
  localparam int XLEN      = 32;

  localparam logic [CDB_BITS-1:0] ZERO_REG_PR = '0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } flush_state_e;

  typedef struct packed {
    logic                valid;
    logic [CDB_BITS-1:0] tag;
  } flush_lane_t;

endpackage

// File: rtl/flush_lane_sel.sv
// Picks the N_WAY snapshot entries starting at idx and marks which ones carry a
// returnable tag; also counts the valid lanes for the freed-tag tally.
module flush_lane_sel
  import rob_flush_ctrl_pkg::*;
#(
  parameter int N_WAY = CFG_N_WAY,
  parameter int N_ROB = CFG_N_ROB,
  parameter int IDX_W = $clog2(N_ROB) + 1
) (
  input  logic [CDB_BITS-1:0] snap_i      [N_ROB],
  input  logic [IDX_W-1:0]    idx_i,
  output flush_lane_t         lanes_o     [N_WAY],
  output logic [IDX_W-1:0]    valid_cnt_o
);

  localparam int SEL_W = (N_ROB > 1) ? $clog2(N_ROB) : 1;

  logic [IDX_W:0] pos [N_WAY];

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a latch.
    valid_cnt_o = '0;
    for (int i = 0; i < N_WAY; i++) begin
      pos[i]     = {1'b0, idx_i} + (IDX_W + 1)'(i);
      lanes_o[i] = '0;
      // Lanes past the end of the ROB (partial last group) stay invalid with tag 0.
      if (pos[i] < (IDX_W + 1)'(N_ROB)) begin
        lanes_o[i].tag   = snap_i[pos[i][SEL_W-1:0]];
        lanes_o[i].valid = (lanes_o[i].tag != '0) && (lanes_o[i].tag != ZERO_REG_PR);
      end
      valid_cnt_o = valid_cnt_o + IDX_W'(lanes_o[i].valid);
    end
  end

endmodule

// File: rtl/rob_flush_ctrl.sv
// Branch-misprediction recovery: snapshot squashed tags, drain them to the free
// list under fl_ready, then pulse a fetch redirect. Also tracks a sticky halt.
module rob_flush_ctrl
  import rob_flush_ctrl_pkg::*;
#(
  parameter int N_WAY = CFG_N_WAY,
  parameter int N_ROB = CFG_N_ROB,
  parameter int TAG_W = CDB_BITS,
  parameter int PC_W  = XLEN
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       branch_haz,
  input  logic [PC_W-1:0]            br_target_pc,
  input  logic [N_ROB*TAG_W-1:0]     free_list_haz,
  input  logic [N_WAY-1:0]           retire_halt,
  input  logic                       fl_ready,
  output logic [N_WAY-1:0]           fl_free_valid,
  output logic [N_WAY*TAG_W-1:0]     fl_free_tag,
  output logic                       dispatch_stall,
  output logic                       fetch_redirect,
  output logic [PC_W-1:0]            fetch_redirect_pc,
  output logic                       flush_busy,
  output logic                       halted,
  output logic [$clog2(N_ROB):0]     freed_cnt,
  output logic                       proto_err
);

  localparam int IDX_W = $clog2(N_ROB) + 1;

  flush_state_e      state_q, state_d;
  logic [TAG_W-1:0]  snap_q [N_ROB];
  logic [TAG_W-1:0]  snap_d [N_ROB];
  logic [PC_W-1:0]   tgt_pc_q, tgt_pc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  freed_cnt_q, freed_cnt_d;
  logic              halted_q, halted_d;
  logic              proto_err_q, proto_err_d;

  flush_lane_t       lanes [N_WAY];
  logic [IDX_W-1:0]  valid_cnt;
  logic [IDX_W:0]    idx_sum;

  flush_lane_sel #(
    .N_WAY (N_WAY),
    .N_ROB (N_ROB),
    .IDX_W (IDX_W)
  ) u_lane_sel (
    .snap_i      (snap_q),
    .idx_i       (idx_q),
    .lanes_o     (lanes),
    .valid_cnt_o (valid_cnt)
  );

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      tgt_pc_q    <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      freed_cnt_q <= '0;
      halted_q    <= 1'b0;
      proto_err_q <= 1'b0;
      // NOTE: the snapshot is cleared on reset so an aborted flush leaves no stale tags behind.
      for (int k = 0; k < N_ROB; k++) snap_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      tgt_pc_q    <= tgt_pc_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      freed_cnt_q <= freed_cnt_d;
      halted_q    <= halted_d;
      proto_err_q <= proto_err_d;
      for (int k = 0; k < N_ROB; k++) snap_q[k] <= snap_d[k];
    end
  end

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    tgt_pc_d    = tgt_pc_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    freed_cnt_d = freed_cnt_q;
    halted_d    = halted_q | (|retire_halt);
    proto_err_d = proto_err_q;
    idx_sum     = {1'b0, idx_q} + (IDX_W + 1)'(N_WAY);

    unique case (state_q)
      IDLE: begin
        if (branch_haz) begin
          for (int k = 0; k < N_ROB; k++) snap_d[k] = free_list_haz[k*TAG_W +: TAG_W];
          tgt_pc_d = br_target_pc;
          idx_d    = '0;
          cnt_d    = '0;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        proto_err_d = proto_err_q | branch_haz;
        // Every group costs one accepted handshake, even when all its lanes are empty.
        if (fl_ready) begin
          idx_d = idx_sum[IDX_W-1:0];
          cnt_d = cnt_q + valid_cnt;
          if (idx_sum >= (IDX_W + 1)'(N_ROB)) state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        proto_err_d = proto_err_q | branch_haz;
        freed_cnt_d = cnt_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fl_free_valid     = '0;
    fl_free_tag       = '0;
    fetch_redirect    = (state_q == REDIRECT);
    fetch_redirect_pc = (state_q == REDIRECT) ? tgt_pc_q : '0;
    flush_busy        = (state_q != IDLE);
    dispatch_stall    = branch_haz | (state_q != IDLE) | halted_q;
    halted            = halted_q;
    freed_cnt         = freed_cnt_q;
    proto_err         = proto_err_q;
    if (state_q == DRAIN) begin
      for (int i = 0; i < N_WAY; i++) begin
        fl_free_valid[i]             = lanes[i].valid;
        fl_free_tag[i*TAG_W +: TAG_W] = lanes[i].tag;
      end
    end
  end

endmodule

// File: tb/tb_rob_flush_ctrl.sv
// Directed bench for rob_flush_ctrl with N_ROB=8, N_WAY=2, 6-bit tags.
module tb_rob_flush_ctrl;

  localparam int N_WAY = 2;
  localparam int N_ROB = 8;
  localparam int TAG_W = 6;
  localparam int PC_W  = 32;

  typedef logic [TAG_W-1:0] tag_arr_t [N_ROB];

  logic                   clock;
  logic                   reset;
  logic                   branch_haz;
  logic [PC_W-1:0]        br_target_pc;
  logic [N_ROB*TAG_W-1:0] free_list_haz;
  logic [N_WAY-1:0]       retire_halt;
  logic                   fl_ready;
  logic [N_WAY-1:0]       fl_free_valid;
  logic [N_WAY*TAG_W-1:0] fl_free_tag;
  logic                   dispatch_stall;
  logic                   fetch_redirect;
  logic [PC_W-1:0]        fetch_redirect_pc;
  logic                   flush_busy;
  logic                   halted;
  logic [3:0]             freed_cnt;
  logic                   proto_err;

  int n_tests = 0;
  int n_fail  = 0;

  rob_flush_ctrl #(
    .N_WAY (N_WAY),
    .N_ROB (N_ROB),
    .TAG_W (TAG_W),
    .PC_W  (PC_W)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .branch_haz        (branch_haz),
    .br_target_pc      (br_target_pc),
    .free_list_haz     (free_list_haz),
    .retire_halt       (retire_halt),
    .fl_ready          (fl_ready),
    .fl_free_valid     (fl_free_valid),
    .fl_free_tag       (fl_free_tag),
    .dispatch_stall    (dispatch_stall),
    .fetch_redirect    (fetch_redirect),
    .fetch_redirect_pc (fetch_redirect_pc),
    .flush_busy        (flush_busy),
    .halted            (halted),
    .freed_cnt         (freed_cnt),
    .proto_err         (proto_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [N_ROB*TAG_W-1:0] pack_tags(input tag_arr_t t);
    logic [N_ROB*TAG_W-1:0] r;
    for (int k = 0; k < N_ROB; k++) r[k*TAG_W +: TAG_W] = t[k];
    return r;
  endfunction

  task automatic clear_inputs();
    branch_haz    = 1'b0;
    br_target_pc  = '0;
    free_list_haz = '0;
    retire_halt   = '0;
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, " valid"},    fl_free_valid,     0);
    check({nm, " tag"},      fl_free_tag,       0);
    check({nm, " stall"},    dispatch_stall,    0);
    check({nm, " redirect"}, fetch_redirect,    0);
    check({nm, " pc"},       fetch_redirect_pc, 0);
    check({nm, " busy"},     flush_busy,        0);
    check({nm, " halted"},   halted,            0);
    check({nm, " freed"},    freed_cnt,         0);
    check({nm, " proto"},    proto_err,         0);
  endtask

  // evt_kind: 0 none, 1 second branch_haz, 2 retire_halt=2'b10; injected in group evt_group.
  task automatic do_flush(input tag_arr_t t, input logic [PC_W-1:0] pc, input int bp_group,
                          input int bp_len, input int evt_group, input int evt_kind,
                          input int exp_freed, input logic exp_stall_after, input string nm);
    logic [N_WAY-1:0]       ev;
    logic [N_WAY*TAG_W-1:0] et;
    int                     hold;
    branch_haz    = 1'b1;
    br_target_pc  = pc;
    free_list_haz = pack_tags(t);
    fl_ready      = 1'b1;
    #2;
    check($sformatf("%s haz stall", nm), dispatch_stall, 1);
    check($sformatf("%s haz busy", nm),  flush_busy,     0);
    check($sformatf("%s haz valid", nm), fl_free_valid,  0);
    tick();
    clear_inputs();
    for (int g = 0; g < N_ROB / N_WAY; g++) begin
      ev   = {t[2*g+1] != 0, t[2*g] != 0};
      et   = {t[2*g+1], t[2*g]};
      hold = (g == bp_group) ? bp_len : 0;
      for (int h = 0; h <= hold; h++) begin
        fl_ready = (h < hold) ? 1'b0 : 1'b1;
        if (g == evt_group && h == 0 && evt_kind == 1) begin
          branch_haz    = 1'b1;
          br_target_pc  = 32'h000d_ead0;
          free_list_haz = {N_ROB{6'h3f}};
        end
        if (g == evt_group && h == 0 && evt_kind == 2) retire_halt = 2'b10;
        #2;
        check($sformatf("%s g%0d h%0d valid", nm, g, h), fl_free_valid,  ev);
        check($sformatf("%s g%0d h%0d tag", nm, g, h),   fl_free_tag,    et);
        check($sformatf("%s g%0d stall", nm, g),         dispatch_stall, 1);
        check($sformatf("%s g%0d busy", nm, g),          flush_busy,     1);
        check($sformatf("%s g%0d redirect", nm, g),      fetch_redirect, 0);
        tick();
        clear_inputs();
      end
    end
    fl_ready = 1'b1;
    #2;
    check($sformatf("%s redirect", nm),       fetch_redirect,    1);
    check($sformatf("%s redirect pc", nm),    fetch_redirect_pc, pc);
    check($sformatf("%s redirect stall", nm), dispatch_stall,    1);
    check($sformatf("%s redirect valid", nm), fl_free_valid,     0);
    tick();
    #2;
    check($sformatf("%s post redirect", nm), fetch_redirect, 0);
    check($sformatf("%s post busy", nm),     flush_busy,     0);
    check($sformatf("%s freed_cnt", nm),     freed_cnt,      exp_freed);
    check($sformatf("%s post stall", nm),    dispatch_stall, exp_stall_after);
  endtask

  initial begin
    tag_arr_t basic;
    tag_arr_t zeros;
    basic = '{6'd5, 6'd6, 6'd0, 6'd9, 6'd0, 6'd0, 6'd12, 6'd3};
    zeros = '{default: 6'd0};

    clear_inputs();
    fl_ready = 1'b0;
    reset    = 1'b1;
    tick();
    tick();
    #2;
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();

    do_flush(basic, 32'h0000_1040, -1, 0, -1, 0, 5, 1'b0, "basic");
    do_flush(basic, 32'h0000_1040, 1, 3, -1, 0, 5, 1'b0, "bp");
    check("bp proto_err", proto_err, 0);
    do_flush(zeros, 32'h0000_2000, -1, 0, -1, 0, 0, 1'b0, "zero");
    do_flush(basic, 32'h0000_1040, -1, 0, 1, 1, 5, 1'b0, "dbl");
    check("dbl proto_err", proto_err, 1);
    do_flush(basic, 32'h0000_3000, -1, 0, 1, 2, 5, 1'b1, "halt");
    check("halt halted", halted, 1);
    tick();
    check("halt stall sticky", dispatch_stall, 1);

    // Abort a flush with reset during its second DRAIN cycle.
    branch_haz    = 1'b1;
    br_target_pc  = 32'h0000_1040;
    free_list_haz = pack_tags(basic);
    fl_ready      = 1'b1;
    tick();
    clear_inputs();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    check_idle_outputs("rst_mid");
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("rst_mid c%0d redirect", c), fetch_redirect, 0);
      check($sformatf("rst_mid c%0d busy", c),     flush_busy,     0);
    end
    do_flush(basic, 32'h0000_1040, -1, 0, -1, 0, 5, 1'b0, "post_rst");
    check("post_rst proto_err", proto_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
